piso_shifter: RTL and testbench
===============================

// Module: piso_shifter
// PURPOSE
//   Parallel-in/serial-out shift register. Accepts an N-bit word over a
//   valid/ready handshake and emits it one bit per accepted cycle.
//   Sits directly upstream of mux2: o_bit drives a mux2 select line, so
//   the mux steps through in0/in1 under control of the loaded pattern.
//   Back-to-back words stream with no bubble; the consumer can stall it
//   via o_ready.
// PARAMETERS
//   N          8   word width in bits; N >= 2
//   MSB_FIRST  1   1: emit bit N-1 first; 0: emit bit 0 first
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   ena      in   1      global enable; 0 freezes all state
//   i_data   in   N      parallel word to serialise
//   i_valid  in   1      i_data is valid
//   i_ready  out  1      shifter can accept a word this cycle
//   o_bit    out  1      current serial bit (to mux2 select)
//   o_valid  out  1      o_bit is valid
//   o_ready  in   1      consumer takes o_bit this cycle
//   o_last   out  1      o_bit is the final bit of the word
// BEHAVIOUR
//   State: IDLE, SHIFT. Internal: shreg[N-1:0], cnt[$clog2(N)-1:0].
//   Reset (rst=1 at posedge, ena is ignored):
//   - state=IDLE, shreg=0, cnt=0.
//   - Outputs: o_valid=0, o_last=0, o_bit=0.
//   Combinational outputs:
//   - o_valid = (state==SHIFT).
//   - o_bit = MSB_FIRST ? shreg[N-1] : shreg[0]; forced 0 when o_valid=0.
//   - o_last = o_valid & (cnt==N-1).
//   - i_ready = ena & (state==IDLE | (o_last & o_ready)).
//   Events:
//   - Load: i_valid & i_ready. At the next edge: shreg<=i_data, cnt<=0,
//     state<=SHIFT.
//   - Take: ena & o_valid & o_ready. Shift shreg one place toward the
//     output end, zero-filling; cnt<=cnt+1.
//   Transitions (ena=1):
//   - IDLE, load -> SHIFT. IDLE, no load -> IDLE.
//   - SHIFT, take, cnt<N-1 -> SHIFT.
//   - SHIFT, take & o_last & load -> SHIFT with the new word; load wins
//     over shift. This gives zero bubble between words.
//   - SHIFT, take & o_last, no load -> IDLE.
//   - SHIFT, o_ready=0 -> hold; o_bit and o_last stay stable.
//   Stall and enable rules:
//   - ena=0: no state change at all; i_ready=0.
//   - o_valid, o_bit and o_last keep their current values under ena=0.
//   Latency: first bit is valid the cycle after the load edge. A word
//     takes exactly N take-cycles to drain.
//   Boundary conditions:
//   - i_valid while busy and not on the last bit: ignored, not latched.
//     The source must hold i_valid until it sees i_ready.
//   - cnt never exceeds N-1; it does not wrap.
//   - rst mid-word: the word is discarded. o_valid=0 on the next cycle.
//   - rst has priority over every other event.
// TESTING
//   1. N=8, MSB_FIRST=1. Load 8'b1011_0010, o_ready=1 -> o_bit sequence
//      1,0,1,1,0,0,1,0 on 8 consecutive cycles. o_last=1 on cycle 8 only;
//      then o_valid=0 and i_ready=1.
//   2. MSB_FIRST=0. Load 8'hA5 -> o_bit 1,0,1,0,0,1,0,1.
//   3. Back-to-back: hold i_valid=1. Load 8'hFF then 8'h00 -> 16 contiguous
//      valid cycles (8 ones, then 8 zeros) with no o_valid gap. i_ready=1
//      on the o_last cycle.
//   4. Backpressure: deassert o_ready for 3 cycles after the 3rd bit ->
//      o_bit/o_last are stable while stalled, and the sequence resumes
//      with no bit lost or duplicated.
//   5. ena=0 for 2 cycles mid-word, i_valid=1 -> i_ready=0 and cnt/shreg
//      unchanged; output matches the ena=1 run delayed by 2 cycles.
//   6. rst after the 4th bit of 8'hF0 -> the next cycle has o_valid=0 and
//      i_ready=1. A fresh load of 8'h81 then emits 1,0,0,0,0,0,0,1.
//      Also drive o_bit into mux2 (in0=0, in1=1) and check mux out===o_bit.

Source files
------------

// File: rtl/piso_shifter_if.sv
// Handshake bundle for the parallel-in/serial-out shifter: word input side
// (i_*) and serial bit output side (o_*), grouped so both travel as one port.
interface piso_shifter_if #(
    parameter int N = 8
);
    // Both sides use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid must not wait on ready, and the
    // source holds its payload stable until the transfer happens.
    logic [N-1:0] i_data;
    logic         i_valid;
    logic         i_ready;
    logic         o_bit;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;

    modport slave (
        input  i_data, i_valid, o_ready,
        output i_ready, o_bit, o_valid, o_last
    );

    modport master (
        output i_data, i_valid, o_ready,
        input  i_ready, o_bit, o_valid, o_last
    );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift register: loads an N-bit word, emits one bit
// per accepted cycle, and reloads on the last bit so words stream bubble-free.
module piso_shifter #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    piso_shifter_if.slave     bus,
    output logic              dbg_state_o
);
    localparam int CW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            out_valid;
    logic            out_last;
    logic            out_bit;
    logic            in_ready;
    logic            load;
    logic            take;
    logic [N-1:0]    shifted;

    always_comb begin
        out_valid = (state_q == SHIFT);
        out_bit   = out_valid & (MSB_FIRST ? shreg_q[N-1] : shreg_q[0]);
        out_last  = out_valid & (cnt_q == CW'(N - 1));
        in_ready  = ena & ((state_q == IDLE) | (out_last & bus.o_ready));
        load      = bus.i_valid & in_ready;
        take      = ena & out_valid & bus.o_ready;
        shifted   = MSB_FIRST ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
    end

    // A load on the last bit overrides the shift, giving the zero-bubble handoff.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = SHIFT;
            shreg_d = bus.i_data;
            cnt_d   = '0;
        end else if (take) begin
            shreg_d = shifted;
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_valid = out_valid;
    assign bus.o_bit   = out_bit;
    assign bus.o_last  = out_last;
    assign bus.i_ready = in_ready;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: a vector table on an MSB-first instance
// plus hand-written sequences for reset state and an LSB-first instance.
module tb_piso_shifter;
    logic clk;
    logic rst;
    logic ena;
    logic msb_state;
    logic lsb_state;

    int n_checks = 0;
    int n_fail   = 0;

    piso_shifter_if #(.N(8)) msb_if ();
    piso_shifter_if #(.N(8)) lsb_if ();

    piso_shifter #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .bus         (msb_if.slave),
        .dbg_state_o (msb_state)
    );

    piso_shifter #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .bus         (lsb_if.slave),
        .dbg_state_o (lsb_state)
    );

    // Downstream 2:1 mux selected by the serial bit (in0=0, in1=1).
    localparam logic MUX_IN0 = 1'b0;
    localparam logic MUX_IN1 = 1'b1;
    wire mux_out = msb_if.o_bit ? MUX_IN1 : MUX_IN0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       ena;
        logic       ivalid;
        logic [7:0] idata;
        logic       oready;
        logic       ev;
        logic       eb;
        logic       el;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic en, input logic iv,
                                input logic [7:0] id, input logic ordy,
                                input logic ev, input logic eb,
                                input logic el, input logic er);
        vec_t v;
        v.rst = r; v.ena = en; v.ivalid = iv; v.idata = id; v.oready = ordy;
        v.ev = ev; v.eb = eb; v.el = el; v.er = er;
        vecs.push_back(v);
    endfunction

    // Idle cycle presenting (iv, id): nothing valid, ready to accept.
    function automatic void add_idle(input logic iv, input logic [7:0] id);
        add(1'b0, 1'b1, iv, id, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Taken bits k_lo..k_hi of word (MSB first) with o_ready=1.
    function automatic void add_bits(input logic [7:0] w, input int k_lo, input int k_hi,
                                     input logic iv, input logic [7:0] id);
        for (int k = k_lo; k <= k_hi; k++) begin
            add(1'b0, 1'b1, iv, id, 1'b1, 1'b1, w[7-k], (k == 7), (k == 7));
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic apply_vec(input int idx, input vec_t v);
        rst              = v.rst;
        ena              = v.ena;
        msb_if.i_valid   = v.ivalid;
        msb_if.i_data    = v.idata;
        msb_if.o_ready   = v.oready;
        #1;
        check($sformatf("v%0d o_valid", idx), {7'b0, msb_if.o_valid}, {7'b0, v.ev});
        check($sformatf("v%0d o_bit", idx),   {7'b0, msb_if.o_bit},   {7'b0, v.eb});
        check($sformatf("v%0d o_last", idx),  {7'b0, msb_if.o_last},  {7'b0, v.el});
        check($sformatf("v%0d i_ready", idx), {7'b0, msb_if.i_ready}, {7'b0, v.er});
        check($sformatf("v%0d mux_out", idx), {7'b0, mux_out},        {7'b0, v.eb});
        step();
    endtask

    initial begin
        logic [7:0] w_a5;
        w_a5 = 8'hA5;

        rst = 1'b1;
        ena = 1'b0;
        msb_if.i_valid = 1'b0; msb_if.i_data = 8'h00; msb_if.o_ready = 1'b0;
        lsb_if.i_valid = 1'b0; lsb_if.i_data = 8'h00; lsb_if.o_ready = 1'b0;
        repeat (3) step();

        // Reset state
        rst = 1'b0;
        ena = 1'b1;
        #1;
        check("reset o_valid", {7'b0, msb_if.o_valid}, 8'h00);
        check("reset o_bit",   {7'b0, msb_if.o_bit},   8'h00);
        check("reset o_last",  {7'b0, msb_if.o_last},  8'h00);
        check("reset i_ready", {7'b0, msb_if.i_ready}, 8'h01);
        check("reset state",   {7'b0, msb_state},      8'h00);
        check("reset lsb o_valid", {7'b0, lsb_if.o_valid}, 8'h00);

        // Single word 1011_0010
        add_idle(1'b1, 8'hB2);
        add_bits(8'hB2, 0, 7, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        // Back-to-back FF then 00 with i_valid held high
        add_idle(1'b1, 8'hFF);
        add_bits(8'hFF, 0, 7, 1'b1, 8'h00);
        add_bits(8'h00, 0, 7, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        // Backpressure after the 3rd bit: bit index 3 (=1) held for 3 cycles
        add_idle(1'b1, 8'hB2);
        add_bits(8'hB2, 0, 2, 1'b0, 8'h00);
        for (int s = 0; s < 3; s++) add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add_bits(8'hB2, 3, 7, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        // ena=0 for 2 cycles mid-word with a competing word on i_data
        add_idle(1'b1, 8'hB2);
        add_bits(8'hB2, 0, 1, 1'b0, 8'h00);
        for (int s = 0; s < 2; s++) add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_bits(8'hB2, 2, 7, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        // Reset after the 4th bit of F0, then a fresh 81
        add_idle(1'b1, 8'hF0);
        add_bits(8'hF0, 0, 3, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_idle(1'b1, 8'h81);
        add_bits(8'h81, 0, 7, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // LSB-first instance: A5 -> 1,0,1,0,0,1,0,1
        lsb_if.i_valid = 1'b1;
        lsb_if.i_data  = w_a5;
        lsb_if.o_ready = 1'b1;
        #1;
        check("lsb load i_ready", {7'b0, lsb_if.i_ready}, 8'h01);
        step();
        lsb_if.i_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("lsb bit%0d o_valid", k), {7'b0, lsb_if.o_valid}, 8'h01);
            check($sformatf("lsb bit%0d o_bit", k),   {7'b0, lsb_if.o_bit},   {7'b0, w_a5[k]});
            check($sformatf("lsb bit%0d o_last", k),  {7'b0, lsb_if.o_last},  {7'b0, (k == 7)});
            check($sformatf("lsb bit%0d state", k),   {7'b0, lsb_state},      8'h01);
            step();
        end
        #1;
        check("lsb end o_valid", {7'b0, lsb_if.o_valid}, 8'h00);
        check("lsb end i_ready", {7'b0, lsb_if.i_ready}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
